alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one external 4-bit signed ALU between two requesters. Each requester supplies operands A and B and a 3-bit opcode (opt).
- Arbitrates round-robin, latches the winning request, and drives the ALU for exactly one cycle.
- Captures the ALU result and flags, then returns them to the owning requester with a valid/ready handshake.
- Sits between the requesting units and the ALU instance in the npc datapath.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- OPT_W, 3, opcode width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  bit i = requester i has a request.
- req_ready  out  2  bit i = request i accepted this cycle; at most one bit set.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_opt  in  OPT_W  requester 0 opcode.
- req1_a, req1_b  in  WIDTH  requester 1 operands.
- req1_opt  in  OPT_W  requester 1 opcode.
- rsp_valid  out  2  one-hot; bit i = response for requester i.
- rsp_ready  in  2  bit i = requester i takes its response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_flags  out  5  captured {less, equal, carry_out, overflow, zero}.
- alu_a, alu_b  out  WIDTH  operands to the ALU.
- alu_opt  out  OPT_W  opcode to the ALU.
- alu_result  in  WIDTH  ALU result; combinational from alu_*.
- alu_flags  in  5  ALU flags, same packing as rsp_flags.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ISSUE, RESP. Reset value is IDLE.
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, alu_a/alu_b/alu_opt=0, owner=0, last_grant=1 (so requester 0 wins first).
- IDLE:
  - If any req_valid bit is set, grant one requester. If both are set, grant the one that is not last_grant.
  - req_ready[g]=1 combinationally in that same cycle.
  - At the clock edge: latch that requester's a/b/opt into the alu_* registers, set owner=g and last_grant=g, go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - alu_* hold the latched request.
  - At the clock edge: rsp_result<=alu_result, rsp_flags<=alu_flags, go to RESP.
- RESP:
  - rsp_valid[owner]=1.
  - rsp_result and rsp_flags stay stable until rsp_ready[owner]=1; then go to IDLE and clear rsp_valid.
  - rsp_ready of the non-owner is ignored.
  - No new request is accepted in the cycle the response is consumed.
- Latency: accept at cycle T gives rsp_valid at T+2. Minimum issue interval is 3 cycles.
- alu_* keep their last values outside ISSUE; the ALU is combinational, so this is harmless.
- A requester that drops req_valid before it is granted loses nothing. Request contents may change freely while the requester is not granted.
- Reset mid-operation, in any state: return to IDLE and drop the pending response; no rsp_valid is raised afterwards.
- No arithmetic inside the block; result/flag width rules belong to the ALU.

Optional Feature:
- Macro: ALU_ARB_GRANT_CNT_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1, 8 bits each, reset to 0.
  - grant_cnt_i increments on each accept for requester i and saturates at 255.
- When undefined:
  - These ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then req0 ADD (opt 000) a=0111, b=0001 accepted at T → rsp_valid=01 at T+2; result=1000, flags=00010.
- Both requesters valid: req0 SUB 0011-0011, req1 NOT 0101 (opt 010) → req0 granted first with result=0000, flags=00101; then req1 granted with result=1010, flags=00000.
- req1 compare (opt 110) a=1110, b=0001 with rsp_ready held low 5 cycles → rsp_valid and result=1101, flags=10100 stable for all 5 cycles; released 1 cycle after rsp_ready.
- req0 equal (opt 111) a=0101, b=0101 → result=0000, flags=01100; req_ready=00 throughout ISSUE and RESP even with both req_valid high.
- rst asserted in ISSUE → next cycle state is IDLE, rsp_valid=00, busy=0, then req0 is granted first.
- ALU_ARB_GRANT_CNT_EN defined: 300 accepts for req0 → grant_cnt0=255, grant_cnt1=0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional ALU_ARB_GRANT_CNT_EN adds saturating per-requester grant counters.
module alu_req_arbiter #(
  parameter int WIDTH = 4,
  parameter int OPT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPT_W-1:0] req0_opt,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPT_W-1:0] req1_opt,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPT_W-1:0] alu_opt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [4:0]       alu_flags,
  output logic             busy
`ifdef ALU_ARB_GRANT_CNT_EN
  ,
  output logic [7:0]       grant_cnt0,
  output logic [7:0]       grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPT_W-1:0] alu_opt_q, alu_opt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [4:0]       flags_q, flags_d;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_opt_d = alu_opt_q;
    res_d     = res_q;
    flags_d   = flags_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    grant     = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          accept = 1'b1;
          // Contention goes to whoever did not win last time.
          grant     = (&req_valid) ? ~last_q : req_valid[1];
          req_ready = grant ? 2'b10 : 2'b01;
          owner_d   = grant;
          last_d    = grant;
          alu_a_d   = grant ? req1_a : req0_a;
          alu_b_d   = grant ? req1_b : req0_b;
          alu_opt_d = grant ? req1_opt : req0_opt;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        res_d   = alu_result;
        flags_d = alu_flags;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_opt_q <= '0;
      res_q     <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_opt_q <= alu_opt_d;
      res_q     <= res_d;
      flags_q   <= flags_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opt    = alu_opt_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign busy       = (state_q != IDLE);

`ifdef ALU_ARB_GRANT_CNT_EN
  logic [7:0] cnt0_q, cnt0_d;
  logic [7:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (accept && !grant && cnt0_q != 8'hFF) cnt0_d = cnt0_q + 8'd1;
    if (accept && grant && cnt1_q != 8'hFF) cnt1_d = cnt1_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: local 4-bit ALU model plus response scoreboard.
// Counter checks run only when ALU_ARB_GRANT_CNT_EN is defined.
module tb_alu_req_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_opt, req1_opt;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_result;
  logic [4:0] rsp_flags;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_opt;
  logic [3:0] alu_result;
  logic [4:0] alu_flags;
  logic       busy;
`ifdef ALU_ARB_GRANT_CNT_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  typedef struct {
    logic [1:0] who;
    logic [3:0] res;
    logic [4:0] fl;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   vectors = 0;
  int   errs = 0;

  alu_req_arbiter #(.WIDTH(4), .OPT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_opt   (req0_opt),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_opt   (req1_opt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opt    (alu_opt),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .busy       (busy)
`ifdef ALU_ARB_GRANT_CNT_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {result, less, equal, carry, overflow, zero}
  function automatic logic [8:0] alu_model(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic [2:0] op);
    logic [4:0] s, d;
    logic [3:0] r;
    logic l, e, c, v, z;
    s = {1'b0, a} + {1'b0, b};
    d = {1'b0, a} + {1'b0, ~b} + 5'd1;
    l = 1'b0; e = 1'b0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        r = s[3:0]; c = s[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'd1: begin
        r = d[3:0]; c = d[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: begin
        r = d[3:0]; c = d[4];
        l = $signed(a) < $signed(b);
      end
      default: begin
        r = 4'd0; c = d[4];
        e = (a == b);
      end
    endcase
    z = (op < 3'd6) && (r == 4'd0);
    return {r, l, e, c, v, z};
  endfunction

  always_comb {alu_result, alu_flags} = alu_model(alu_a, alu_b, alu_opt);

  function automatic void push(input logic who, input logic [3:0] a,
                               input logic [3:0] b, input logic [2:0] op);
    exp_t e;
    logic [8:0] m;
    m = alu_model(a, b, op);
    e.who = who ? 2'b10 : 2'b01;
    e.res = m[8:5];
    e.fl  = m[4:0];
    sb.push_back(e);
  endfunction

  // A handshake completes on the next rising edge; score it here.
  always @(negedge clk) begin
    if (!rst && (rsp_valid & rsp_ready) != 2'b00) begin
      vectors++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL sb_unexpected_rsp rsp_valid=%b res=%b", rsp_valid, rsp_result);
      end else begin
        got = sb.pop_front();
        if (rsp_valid !== got.who || rsp_result !== got.res || rsp_flags !== got.fl) begin
          errs++;
          $display("FAIL sb_rsp got v=%b r=%b f=%b expected v=%b r=%b f=%b",
                   rsp_valid, rsp_result, rsp_flags, got.who, got.res, got.fl);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    @(negedge clk);
    while (busy !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL drain_timeout busy=%b expected 0", busy);
    end
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req0_a = 4'd0; req0_b = 4'd0; req0_opt = 3'd0;
    req1_a = 4'd0; req1_b = 4'd0; req1_opt = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.delete();
    vectors++;
    if (busy !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
      errs++;
      $display("FAIL reset_ctrl busy=%b rr=%b rv=%b expected 0 00 00", busy, req_ready, rsp_valid);
    end
    vectors++;
    if (rsp_result !== 4'd0 || rsp_flags !== 5'd0 ||
        alu_a !== 4'd0 || alu_b !== 4'd0 || alu_opt !== 3'd0) begin
      errs++;
      $display("FAIL reset_data res=%b fl=%b a=%b b=%b op=%b expected zeros",
               rsp_result, rsp_flags, alu_a, alu_b, alu_opt);
    end
`ifdef ALU_ARB_GRANT_CNT_EN
    vectors++;
    if (grant_cnt0 !== 8'd0 || grant_cnt1 !== 8'd0) begin
      errs++;
      $display("FAIL reset_cnt c0=%0d c1=%0d expected 0 0", grant_cnt0, grant_cnt1);
    end
`endif
    tick();
    rst = 1'b0;
  endtask

  task automatic test_add();
    tick();
    req0_a = 4'b0111; req0_b = 4'b0001; req0_opt = 3'd0;
    req_valid = 2'b01;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b01 || busy !== 1'b0) begin
      errs++;
      $display("FAIL add_accept rr=%b busy=%b expected 01 0", req_ready, busy);
    end
    push(1'b0, req0_a, req0_b, req0_opt);
    tick();
    req_valid = 2'b00;
    req0_a = 4'b1111;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 2'b00 || busy !== 1'b1 || alu_a !== 4'b0111 || alu_b !== 4'b0001) begin
      errs++;
      $display("FAIL add_issue rv=%b busy=%b a=%b b=%b expected 00 1 0111 0001",
               rsp_valid, busy, alu_a, alu_b);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 2'b01 || rsp_result !== 4'b1000 || rsp_flags !== 5'b00010) begin
      errs++;
      $display("FAIL add_rsp rv=%b res=%b fl=%b expected 01 1000 00010",
               rsp_valid, rsp_result, rsp_flags);
    end
    tick();
    rsp_ready = 2'b01;
    @(negedge clk);
    tick();
    rsp_ready = 2'b00;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errs++;
      $display("FAIL add_done rv=%b busy=%b expected 00 0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_res[2];
    logic [4:0] exp_fl[2];
    logic [1:0] exp_v;
    exp_res[0] = 4'b0000; exp_fl[0] = 5'b00101;
    exp_res[1] = 4'b1010; exp_fl[1] = 5'b00000;
    tick();
    req0_a = 4'b0011; req0_b = 4'b0011; req0_opt = 3'd1;
    req1_a = 4'b0101; req1_b = 4'b0000; req1_opt = 3'd2;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      exp_v = (k == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      vectors++;
      if (req_ready !== exp_v) begin
        errs++;
        $display("FAIL rr_grant%0d rr=%b expected %b", k, req_ready, exp_v);
      end
      if (k == 1) push(1'b1, req1_a, req1_b, req1_opt);
      else push(1'b0, req0_a, req0_b, req0_opt);
      tick();
      @(negedge clk);
      vectors++;
      if (req_ready !== 2'b00 || busy !== 1'b1) begin
        errs++;
        $display("FAIL rr_issue%0d rr=%b busy=%b expected 00 1", k, req_ready, busy);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (rsp_valid !== exp_v || rsp_result !== exp_res[k] ||
          rsp_flags !== exp_fl[k] || req_ready !== 2'b00) begin
        errs++;
        $display("FAIL rr_rsp%0d rv=%b res=%b fl=%b rr=%b expected %b %b %b 00",
                 k, rsp_valid, rsp_result, rsp_flags, req_ready,
                 exp_v, exp_res[k], exp_fl[k]);
      end
      tick();
      if (k == 1) req_valid = 2'b00;
    end
    rsp_ready = 2'b00;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      errs++;
      $display("FAIL rr_idle busy=%b rv=%b expected 0 00", busy, rsp_valid);
    end
  endtask

  task automatic test_stall();
    tick();
    req1_a = 4'b1110; req1_b = 4'b0001; req1_opt = 3'd6;
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b10) begin
      errs++;
      $display("FAIL stall_grant rr=%b expected 10", req_ready);
    end
    push(1'b1, req1_a, req1_b, req1_opt);
    tick();
    req_valid = 2'b00;
    req1_a = 4'b0000;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tick();
      rsp_ready = 2'b01;
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 2'b10 || rsp_result !== 4'b1101 || rsp_flags !== 5'b10100) begin
        errs++;
        $display("FAIL stall_hold%0d rv=%b res=%b fl=%b expected 10 1101 10100",
                 i, rsp_valid, rsp_result, rsp_flags);
      end
    end
    tick();
    rsp_ready = 2'b10;
    @(negedge clk);
    tick();
    rsp_ready = 2'b00;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errs++;
      $display("FAIL stall_release rv=%b busy=%b expected 00 0", rsp_valid, busy);
    end
  endtask

  task automatic test_equal_block();
    tick();
    req0_a = 4'b0101; req0_b = 4'b0101; req0_opt = 3'd7;
    req_valid = 2'b01;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b01) begin
      errs++;
      $display("FAIL eq_grant rr=%b expected 01", req_ready);
    end
    push(1'b0, req0_a, req0_b, req0_opt);
    tick();
    req_valid = 2'b11;
    req1_a = 4'b0010; req1_b = 4'b0001; req1_opt = 3'd4;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b00) begin
      errs++;
      $display("FAIL eq_issue_block rr=%b expected 00", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      rsp_ready = (i == 2) ? 2'b01 : 2'b00;
      @(negedge clk);
      vectors++;
      if (req_ready !== 2'b00 || rsp_result !== 4'b0000 || rsp_flags !== 5'b01100) begin
        errs++;
        $display("FAIL eq_resp%0d rr=%b res=%b fl=%b expected 00 0000 01100",
                 i, req_ready, rsp_result, rsp_flags);
      end
    end
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL eq_idle busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    req0_a = 4'b0001; req0_b = 4'b0010; req0_opt = 3'd0;
    req1_a = 4'b0011; req1_b = 4'b0100; req1_opt = 3'd3;
    req_valid = 2'b11;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b10) begin
      errs++;
      $display("FAIL rstmid_grant rr=%b expected 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_in_issue busy=%b expected 1", busy);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      errs++;
      $display("FAIL rstmid_idle busy=%b rv=%b expected 0 00", busy, rsp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 2'b00) begin
        errs++;
        $display("FAIL rstmid_norsp%0d rv=%b expected 00", i, rsp_valid);
      end
    end
    tick();
    req_valid = 2'b11;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b01) begin
      errs++;
      $display("FAIL rstmid_regrant rr=%b expected 01", req_ready);
    end
    push(1'b0, req0_a, req0_b, req0_opt);
    drain();
  endtask

`ifdef ALU_ARB_GRANT_CNT_EN
  task automatic test_grant_cnt();
    int n, k, e;
    n = 0;
    k = 0;
    rsp_ready = 2'b01;
    while (n < 300 && k < 1500) begin
      tick();
      req0_a = 4'($urandom);
      req0_b = 4'($urandom);
      req0_opt = 3'($urandom);
      req_valid = 2'b01;
      @(negedge clk);
      k++;
      if (req_ready === 2'b01) begin
        e = (n > 255) ? 255 : n;
        vectors++;
        if (grant_cnt0 !== 8'(e)) begin
          errs++;
          $display("FAIL cnt_step%0d c0=%0d expected %0d", n, grant_cnt0, e);
        end
        push(1'b0, req0_a, req0_b, req0_opt);
        n++;
      end
    end
    vectors++;
    if (n != 300) begin
      errs++;
      $display("FAIL cnt_timeout accepts=%0d expected 300", n);
    end
    drain();
    @(negedge clk);
    vectors++;
    if (grant_cnt0 !== 8'd255 || grant_cnt1 !== 8'd0) begin
      errs++;
      $display("FAIL cnt_final c0=%0d c1=%0d expected 255 0", grant_cnt0, grant_cnt1);
    end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_reset();
    test_round_robin();
    test_stall();
    test_equal_block();
    test_reset_mid();
`ifdef ALU_ARB_GRANT_CNT_EN
    test_reset();
    test_grant_cnt();
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL sb_leftover entries=%0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
